// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: bus widths, responder FSM states and termination kinds.
package wishbone_pkg;
  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;
  typedef enum logic [1:0] {ACK, ERR, RTY} term_t;
endpackage

// File: rtl/wishbone_responder_mem.sv
// DEPTH x 32 single-port RAM with per-byte write enables and a registered read port.
module wishbone_responder_mem
  import wishbone_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [WB_SEL_W-1:0] sel,
  input  logic [AW-1:0]       idx,
  input  logic [WB_DAT_W-1:0] wdata,
  output logic [WB_DAT_W-1:0] rdata
);
  logic [WB_DAT_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int unsigned i = 0; i < WB_SEL_W; i++) begin
          if (sel[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end
endmodule

// File: rtl/wishbone_responder.sv
// Wishbone classic slave with wait states and byte-lane memory.
// Optional retry injection enabled by defining WB_RESPONDER_RETRY_EN.
module wishbone_responder
  import wishbone_pkg::*;
#(
  parameter int unsigned          DEPTH     = 256,
  parameter logic [WB_ADR_W-1:0]  BASE_ADDR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WB_ADR_W-1:0] adr,
  input  logic [WB_DAT_W-1:0] din,
  output logic [WB_DAT_W-1:0] dout,
  input  logic                cyc,
  input  logic                stb,
  input  logic [WB_SEL_W-1:0] sel,
  input  logic                we,
  output logic                ack,
  output logic                err,
  output logic                rty,
  input  logic [3:0]          wait_states,
  input  logic [3:0]          retry_n,
  output logic [15:0]         access_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_state_t         state;
  logic [3:0]          cnt;
  logic [29:0]         lat_adr;
  logic [WB_DAT_W-1:0] lat_din;
  logic [WB_SEL_W-1:0] lat_sel;
  logic                lat_we;
  logic                rd_resp;
  logic [WB_DAT_W-1:0] mem_q;

  logic                req, term_now, in_range, retry_now, cur_we;
  logic [29:0]         cur_adr, offs;
  logic [WB_DAT_W-1:0] cur_din;
  logic [WB_SEL_W-1:0] cur_sel;
  term_t               kind;

  // With zero wait states the termination is decided on the accepting edge,
  // so the live bus fields are used instead of the (not yet loaded) latches.
  always_comb begin
    req      = cyc & stb;
    cur_adr  = (state == IDLE) ? adr[31:2] : lat_adr;
    cur_din  = (state == IDLE) ? din : lat_din;
    cur_sel  = (state == IDLE) ? sel : lat_sel;
    cur_we   = (state == IDLE) ? we : lat_we;
    offs     = cur_adr - BASE_ADDR[31:2];
    in_range = offs < 30'(DEPTH);
    term_now = req & (((state == IDLE) && (wait_states == 4'd0)) ||
                      ((state == WAIT) && (cnt == 4'd1)));
    if (retry_now)     kind = RTY;
    else if (in_range) kind = ACK;
    else               kind = ERR;
  end

`ifdef WB_RESPONDER_RETRY_EN
  logic [29:0] last_adr;
  logic        last_we, last_vld, lat_rty, differ;
  logic [3:0]  rcnt, rcnt_eff;

  always_comb begin
    differ    = !last_vld || (last_adr != adr[31:2]) || (last_we != we);
    rcnt_eff  = differ ? retry_n : rcnt;
    retry_now = (state == IDLE) ? (rcnt_eff != 4'd0) : lat_rty;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_adr <= '0;
      last_we  <= 1'b0;
      last_vld <= 1'b0;
      lat_rty  <= 1'b0;
      rcnt     <= '0;
    end else if ((state == IDLE) && req) begin
      last_adr <= adr[31:2];
      last_we  <= we;
      last_vld <= 1'b1;
      lat_rty  <= (rcnt_eff != 4'd0);
      rcnt     <= (term_now && (rcnt_eff != 4'd0)) ? rcnt_eff - 4'd1 : rcnt_eff;
    end else if ((state == WAIT) && term_now && lat_rty) begin
      rcnt <= rcnt - 4'd1;
    end
  end

  logic unused_bits;
  assign unused_bits = &{1'b0, adr[1:0]};
`else
  assign retry_now = 1'b0;

  logic unused_bits;
  assign unused_bits = &{1'b0, adr[1:0], retry_n};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_adr      <= '0;
      lat_din      <= '0;
      lat_sel      <= '0;
      lat_we       <= 1'b0;
      ack          <= 1'b0;
      err          <= 1'b0;
      rty          <= 1'b0;
      rd_resp      <= 1'b0;
      access_count <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      rty <= 1'b0;
      case (state)
        IDLE: if (req) begin
          lat_adr <= adr[31:2];
          lat_din <= din;
          lat_sel <= sel;
          lat_we  <= we;
          cnt     <= wait_states;
          state   <= (wait_states == 4'd0) ? RESP : WAIT;
        end
        WAIT: begin
          if (!req) state <= IDLE;
          else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
      if (term_now) begin
        ack     <= (kind == ACK);
        err     <= (kind == ERR);
        rty     <= (kind == RTY);
        rd_resp <= (kind == ACK) && !cur_we;
        if (kind == ACK) access_count <= access_count + 16'd1;
      end
    end
  end

  wishbone_responder_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .en    (term_now && (kind == ACK)),
    .we    (cur_we),
    .sel   (cur_sel),
    .idx   (offs[AW-1:0]),
    .wdata (cur_din),
    .rdata (mem_q)
  );

  assign dout = (ack && rd_resp) ? mem_q : '0;
endmodule

// File: tb/tb_wishbone_responder.sv
// Directed, table-driven bench for wishbone_responder (default DEPTH/BASE_ADDR).
module tb_wishbone_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] adr = '0, din = '0, dout;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0, wait_states = '0, retry_n = '0;
  logic        ack, err, rty;
  logic [15:0] access_count;

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] T_NONE = 3'b000, T_ACK = 3'b001, T_ERR = 3'b010, T_RTY = 3'b100;

  wishbone_responder #(.DEPTH(256), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .adr(adr), .din(din), .dout(dout), .cyc(cyc), .stb(stb),
    .sel(sel), .we(we), .ack(ack), .err(err), .rty(rty), .wait_states(wait_states),
    .retry_n(retry_n), .access_count(access_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Single classic access; lat counts negedges from request launch to termination.
  task automatic access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, input logic [3:0] ws,
                        output logic [2:0] term, output logic [31:0] rd, output int lat);
    @(posedge clk); #1;
    adr = a; din = d; sel = s; we = w; wait_states = ws; cyc = 1'b1; stb = 1'b1;
    term = T_NONE; rd = '0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack | err | rty) begin
        term = {rty, err, ack}; rd = dout; lat = i;
        break;
      end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("term_one_cycle", {29'd0, rty, err, ack}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] adr;
    logic [31:0] din;
    logic [3:0]  sel;
    logic        we;
    logic [3:0]  ws;
    logic [2:0]  term;
    logic        chk_dout;
    logic [31:0] dout;
    int          lat;
    logic [15:0] cnt;
  } vec_t;

  vec_t tbl[15];

  logic [2:0]  t;
  logic [31:0] rd;
  int          lat;
  logic        seen;

  initial begin
    tbl[0]  = '{32'h10,       32'hDEADBEEF, 4'hF, 1'b1, 4'd0, T_ACK, 1'b0, 32'h0,        1, 16'd1};
    tbl[1]  = '{32'h10,       32'h0,        4'hF, 1'b0, 4'd0, T_ACK, 1'b1, 32'hDEADBEEF, 1, 16'd2};
    tbl[2]  = '{32'h20,       32'h11223344, 4'hF, 1'b1, 4'd0, T_ACK, 1'b0, 32'h0,        1, 16'd3};
    tbl[3]  = '{32'h20,       32'h55667788, 4'h5, 1'b1, 4'd0, T_ACK, 1'b0, 32'h0,        1, 16'd4};
    tbl[4]  = '{32'h20,       32'h0,        4'h0, 1'b0, 4'd0, T_ACK, 1'b1, 32'h11663388, 1, 16'd5};
    tbl[5]  = '{32'h00,       32'hA5A50F0F, 4'hF, 1'b1, 4'd2, T_ACK, 1'b0, 32'h0,        3, 16'd6};
    tbl[6]  = '{32'h400,      32'h12345678, 4'hF, 1'b1, 4'd0, T_ERR, 1'b1, 32'h0,        1, 16'd6};
    tbl[7]  = '{32'h400,      32'h0,        4'hF, 1'b0, 4'd0, T_ERR, 1'b1, 32'h0,        1, 16'd6};
    tbl[8]  = '{32'h00,       32'h0,        4'hF, 1'b0, 4'd1, T_ACK, 1'b1, 32'hA5A50F0F, 2, 16'd7};
    tbl[9]  = '{32'h10,       32'h0,        4'hF, 1'b0, 4'd3, T_ACK, 1'b1, 32'hDEADBEEF, 4, 16'd8};
    tbl[10] = '{32'h10,       32'hFFFFFFFF, 4'h0, 1'b1, 4'd0, T_ACK, 1'b0, 32'h0,        1, 16'd9};
    tbl[11] = '{32'h13,       32'h0,        4'h0, 1'b0, 4'd0, T_ACK, 1'b1, 32'hDEADBEEF, 1, 16'd10};
    tbl[12] = '{32'hFFFFFFFC, 32'h0,        4'hF, 1'b1, 4'd0, T_ERR, 1'b0, 32'h0,        1, 16'd10};
    tbl[13] = '{32'h3FC,      32'h0BADF00D, 4'hF, 1'b1, 4'd0, T_ACK, 1'b0, 32'h0,        1, 16'd11};
    tbl[14] = '{32'h3FC,      32'h0,        4'hF, 1'b0, 4'd1, T_ACK, 1'b1, 32'h0BADF00D, 2, 16'd12};

    #12;
    check("reset_outputs", {29'd0, rty, err, ack}, 32'd0);
    check("reset_dout", dout, 32'd0);
    check("reset_count", {16'd0, access_count}, 32'd0);
    #10 rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      access(tbl[i].adr, tbl[i].din, tbl[i].sel, tbl[i].we, tbl[i].ws, t, rd, lat);
      check($sformatf("vec%0d_term", i), {29'd0, t}, {29'd0, tbl[i].term});
      check($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      if (tbl[i].chk_dout) check($sformatf("vec%0d_dout", i), rd, tbl[i].dout);
      check($sformatf("vec%0d_count", i), {16'd0, access_count}, {16'd0, tbl[i].cnt});
    end

    // Abort: W=3 read, stb dropped so the edge two after acceptance sees it low.
    @(posedge clk); #1;
    adr = 32'h10; we = 1'b0; sel = 4'hF; wait_states = 4'd3; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack | err | rty) seen = 1'b1;
    end
    check("abort_no_term", {31'd0, seen}, 32'd0);
    check("abort_count", {16'd0, access_count}, 32'd12);
    access(32'h20, 32'h0, 4'hF, 1'b0, 4'd0, t, rd, lat);
    check("post_abort_term", {29'd0, t}, {29'd0, T_ACK});
    check("post_abort_dout", rd, 32'h11663388);
    check("post_abort_lat", lat, 1);

`ifdef WB_RESPONDER_RETRY_EN
    retry_n = 4'd2;
    begin
      logic [31:0] ra [7];
      logic [2:0]  rt [7];
      ra = '{32'h40, 32'h40, 32'h40, 32'h40, 32'h44, 32'h44, 32'h44};
      rt = '{T_RTY, T_RTY, T_ACK, T_ACK, T_RTY, T_RTY, T_ACK};
      for (int i = 0; i < 7; i++) begin
        access(ra[i], 32'h0, 4'hF, 1'b0, 4'd0, t, rd, lat);
        check($sformatf("retry%0d_term", i), {29'd0, t}, {29'd0, rt[i]});
      end
      check("retry_count", {16'd0, access_count}, 32'd16);
    end
    retry_n = 4'd0;
`endif

    // Reset asserted mid-WAIT (W=5): outputs and count clear immediately.
    @(posedge clk); #1;
    adr = 32'h10; we = 1'b0; sel = 4'hF; wait_states = 4'd5; cyc = 1'b1; stb = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", {29'd0, rty, err, ack}, 32'd0);
    check("rst_mid_dout", dout, 32'd0);
    check("rst_mid_count", {16'd0, access_count}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    access(32'h10, 32'h0, 4'hF, 1'b0, 4'd0, t, rd, lat);
    check("post_rst_term", {29'd0, t}, {29'd0, T_ACK});
    check("post_rst_dout", rd, 32'hDEADBEEF);
    check("post_rst_count", {16'd0, access_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
